// File: rtl/bloke2_pkg.sv
// Shared types and constants for the bloke2 message blocker.
// Block sizes cover both hash variants; the state enum is used by the top FSM.
package bloke2_pkg;

    localparam int BLAKE2S_BLOCK = 64;
    localparam int BLAKE2B_BLOCK = 128;
    localparam int BLOKE2_CNT_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2,
        ST_EMIT = 2'd3
    } blk_state_e;

endpackage

// File: rtl/bloke2_lane_wr.sv
// Maps one input beat onto the block buffer: a byte mask covering
// [fill, fill+nbytes) and the beat data shifted to that byte offset.
module bloke2_lane_wr #(
    parameter int W_BYTES     = 1,
    parameter int BLOCK_BYTES = 64,
    parameter int FILL_W      = $clog2(BLOCK_BYTES) + 1,
    parameter int NB_W        = $clog2(W_BYTES) + 1
) (
    input  logic [FILL_W-1:0]        fill_i,
    input  logic [NB_W-1:0]          nbytes_i,
    input  logic [8*W_BYTES-1:0]     din_i,
    output logic [8*BLOCK_BYTES-1:0] wr_mask_o,
    output logic [8*BLOCK_BYTES-1:0] wr_data_o
);

    localparam int EW = FILL_W + 1;

    logic [EW-1:0] lo;
    logic [EW-1:0] hi;

    // One extra bit so fill + nbytes never wraps when the beat completes the block.
    always_comb begin
        lo = {1'b0, fill_i};
        hi = lo + EW'(nbytes_i);
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            wr_mask_o[8*k +: 8] = (EW'(k) >= lo && EW'(k) < hi) ? 8'hFF : 8'h00;
        end
    end

    assign wr_data_o = ((8*BLOCK_BYTES)'(din_i) << {fill_i, 3'b000}) & wr_mask_o;

endmodule

// File: rtl/bloke2_msg_blocker.sv
// Packs a W-byte beat stream into message blocks tagged with byte count and final flag.
//   state | meaning
//   IDLE  | no message in progress, inputs ignored
//   FILL  | accepting beats into the block buffer
//   HOLD  | buffer full, waiting to learn whether more data or finish follows
//   EMIT  | block offered downstream, outputs frozen until handshake
module bloke2_msg_blocker
    import bloke2_pkg::*;
#(
    parameter int W_BYTES     = 1,
    parameter int BLOCK_BYTES = BLAKE2S_BLOCK,
    parameter int CNT_W       = BLOKE2_CNT_W,
    parameter int NB_W        = $clog2(W_BYTES) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     finish,
    input  logic [8*W_BYTES-1:0]     din,
    input  logic [NB_W-1:0]          din_nbytes,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic [8*BLOCK_BYTES-1:0] blk,
    output logic [CNT_W-1:0]         blk_cnt,
    output logic                     blk_last,
    output logic                     blk_valid,
    input  logic                     blk_ready
);

    localparam int FILL_W = $clog2(BLOCK_BYTES) + 1;

    blk_state_e               state_q, state_d;
    logic [8*BLOCK_BYTES-1:0] buf_q, buf_d;
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     last_q, last_d;

    logic [8*BLOCK_BYTES-1:0] wr_mask;
    logic [8*BLOCK_BYTES-1:0] wr_data;
    logic [FILL_W-1:0]        fill_sum;

    bloke2_lane_wr #(
        .W_BYTES    (W_BYTES),
        .BLOCK_BYTES(BLOCK_BYTES),
        .FILL_W     (FILL_W),
        .NB_W       (NB_W)
    ) u_lane_wr (
        .fill_i   (fill_q),
        .nbytes_i (din_nbytes),
        .din_i    (din),
        .wr_mask_o(wr_mask),
        .wr_data_o(wr_data)
    );

    assign fill_sum = fill_q + FILL_W'(din_nbytes);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (start) begin
            buf_d   = '0;
            fill_d  = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = ST_FILL;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_FILL: begin
                    if (din_valid) begin
                        buf_d  = (buf_q & ~wr_mask) | wr_data;
                        fill_d = fill_sum;
                        cnt_d  = cnt_q + CNT_W'(din_nbytes);
                    end
                    if (finish) begin
                        last_d  = 1'b1;
                        state_d = ST_EMIT;
                    end else if (din_valid && fill_sum >= FILL_W'(BLOCK_BYTES)) begin
                        state_d = ST_HOLD;
                    end
                end
                // A full block is only released as non-final once another beat shows up.
                ST_HOLD: begin
                    if (finish) begin
                        last_d  = 1'b1;
                        state_d = ST_EMIT;
                    end else if (din_valid) begin
                        last_d  = 1'b0;
                        state_d = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (blk_ready) begin
                        if (last_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            buf_d   = '0;
                            fill_d  = '0;
                            state_d = ST_FILL;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign din_ready = (state_q == ST_FILL);
    assign blk_valid = (state_q == ST_EMIT);
    assign blk       = buf_q;
    assign blk_cnt   = cnt_q;
    assign blk_last  = last_q;

endmodule

// File: tb/tb_bloke2_msg_blocker.sv
// Bench for bloke2_msg_blocker: a 1-byte/64-byte instance and a 4-byte/128-byte instance,
// with expected blocks queued as stimulus is driven and compared when handed off.
module tb_bloke2_msg_blocker;

    typedef struct {
        logic [1023:0] blk;
        logic [63:0]   cnt;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 1-byte beats, 64-byte blocks
    logic         s_start = 0, s_finish = 0, s_valid = 0, s_blk_ready = 1;
    logic [7:0]   s_din = 0;
    logic [0:0]   s_nbytes = 1'b1;
    logic         s_din_ready, s_blk_last, s_blk_valid;
    logic [511:0] s_blk;
    logic [63:0]  s_blk_cnt;

    // 4-byte beats, 128-byte blocks
    logic          b_start = 0, b_finish = 0, b_valid = 0, b_blk_ready = 1;
    logic [31:0]   b_din = 0;
    logic [2:0]    b_nbytes = 3'd4;
    logic          b_din_ready, b_blk_last, b_blk_valid;
    logic [1023:0] b_blk;
    logic [63:0]   b_blk_cnt;

    int n_checks = 0;
    int n_fail = 0;
    exp_t q_s[$];
    exp_t q_b[$];

    bloke2_msg_blocker #(.W_BYTES(1), .BLOCK_BYTES(64), .CNT_W(64)) u_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .finish(s_finish),
        .din(s_din), .din_nbytes(s_nbytes), .din_valid(s_valid), .din_ready(s_din_ready),
        .blk(s_blk), .blk_cnt(s_blk_cnt), .blk_last(s_blk_last),
        .blk_valid(s_blk_valid), .blk_ready(s_blk_ready)
    );

    bloke2_msg_blocker #(.W_BYTES(4), .BLOCK_BYTES(128), .CNT_W(64)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .finish(b_finish),
        .din(b_din), .din_nbytes(b_nbytes), .din_valid(b_valid), .din_ready(b_din_ready),
        .blk(b_blk), .blk_cnt(b_blk_cnt), .blk_last(b_blk_last),
        .blk_valid(b_blk_valid), .blk_ready(b_blk_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int first;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            first = 0;
            for (int k = 127; k >= 0; k--) if (obs[8*k +: 8] !== exp[8*k +: 8]) first = k;
            $error("FAIL %s: byte %0d observed %h expected %h", tag, first,
                   obs[8*first +: 8], exp[8*first +: 8]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (s_blk_valid && s_blk_ready) begin
            if (q_s.size() == 0) begin
                n_checks++; n_fail++;
                $error("FAIL s_unexpected_blk: observed block with cnt %0d, required none", s_blk_cnt);
            end else begin
                e = q_s.pop_front();
                check_blk("s_blk", 1024'(s_blk), e.blk);
                check("s_blk_cnt", s_blk_cnt, e.cnt);
                check("s_blk_last", 64'(s_blk_last), 64'(e.last));
            end
        end
        if (b_blk_valid && b_blk_ready) begin
            if (q_b.size() == 0) begin
                n_checks++; n_fail++;
                $error("FAIL b_unexpected_blk: observed block with cnt %0d, required none", b_blk_cnt);
            end else begin
                e = q_b.pop_front();
                check_blk("b_blk", b_blk, e.blk);
                check("b_blk_cnt", b_blk_cnt, e.cnt);
                check("b_blk_last", 64'(b_blk_last), 64'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_s(input logic [1023:0] blk, input logic [63:0] cnt, input logic last);
        exp_t e;
        e.blk = blk; e.cnt = cnt; e.last = last;
        q_s.push_back(e);
    endtask

    task automatic push_b(input logic [1023:0] blk, input logic [63:0] cnt, input logic last);
        exp_t e;
        e.blk = blk; e.cnt = cnt; e.last = last;
        q_b.push_back(e);
    endtask

    task automatic s_send(input logic [7:0] b);
        int n = 0;
        s_din = b;
        s_valid = 1'b1;
        while (!s_din_ready && n < 200) begin tick(); n++; end
        if (n >= 200) check("s_send_timeout", 64'(n), 64'(0));
        tick();
        s_valid = 1'b0;
    endtask

    task automatic b_send(input logic [31:0] d, input logic [2:0] nb);
        int n = 0;
        b_din = d;
        b_nbytes = nb;
        b_valid = 1'b1;
        while (!b_din_ready && n < 200) begin tick(); n++; end
        if (n >= 200) check("b_send_timeout", 64'(n), 64'(0));
        tick();
        b_valid = 1'b0;
    endtask

    task automatic s_pulse_start();  s_start = 1; tick(); s_start = 0;  endtask
    task automatic s_pulse_finish(); s_finish = 1; tick(); s_finish = 0; endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((q_s.size() != 0 || q_b.size() != 0) && n < 200) begin tick(); n++; end
        check(tag, 64'(q_s.size() + q_b.size()), 64'(0));
    endtask

    function automatic logic [1023:0] ramp(input int nbytes, input int base);
        logic [1023:0] r = '0;
        for (int k = 0; k < nbytes; k++) r[8*k +: 8] = 8'(base + k);
        return r;
    endfunction

    initial begin
        logic [1023:0] e;

        // reset state
        repeat (2) tick();
        check("rst_s_din_ready", 64'(s_din_ready), 0);
        check("rst_s_blk_valid", 64'(s_blk_valid), 0);
        check("rst_b_blk_last", 64'(b_blk_last), 0);
        check("rst_b_blk_cnt", b_blk_cnt, 0);
        check_blk("rst_b_blk", b_blk, '0);
        rst_n = 1'b1;
        tick();
        check("idle_din_ready", 64'(s_din_ready), 0);

        // 1: empty message
        s_pulse_start();
        check("fill_din_ready", 64'(s_din_ready), 1);
        push_s('0, 0, 1'b1);
        s_pulse_finish();
        check("empty_latency", 64'(s_blk_valid), 1);
        wait_drain("drain_empty");

        // 2: "abc"
        s_pulse_start();
        s_send(8'h61); s_send(8'h62); s_send(8'h63);
        push_s(ramp(3, 'h61), 3, 1'b1);
        s_pulse_finish();
        wait_drain("drain_abc");

        // 3: exactly one block, no trailing empty block
        s_pulse_start();
        for (int i = 0; i < 64; i++) s_send(8'(i));
        check("full_din_ready", 64'(s_din_ready), 0);
        check("full_no_valid", 64'(s_blk_valid), 0);
        push_s(ramp(64, 0), 64, 1'b1);
        s_pulse_finish();
        wait_drain("drain_64");
        check("after_last_ready", 64'(s_din_ready), 0);

        // 4: 65 bytes, first block released only when byte 65 is offered
        s_pulse_start();
        for (int i = 0; i < 64; i++) s_send(8'(i));
        repeat (3) tick();
        check("hold_no_valid", 64'(s_blk_valid), 0);
        push_s(ramp(64, 0), 64, 1'b0);
        s_din = 8'h40; s_valid = 1'b1;
        tick();
        check("overflow_latency", 64'(s_blk_valid), 1);
        s_send(8'h40);
        push_s(ramp(1, 'h40), 65, 1'b1);
        s_pulse_finish();
        wait_drain("drain_65");

        // 5: wide beats, partial last beat, backpressure
        b_start = 1; tick(); b_start = 0;
        b_send(32'h04030201, 3'd4);
        b_send(32'hAA070605, 3'd3);
        e = ramp(7, 1);
        b_blk_ready = 1'b0;
        push_b(e, 7, 1'b1);
        b_finish = 1; tick(); b_finish = 0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(b_blk_valid), 1);
            check("bp_cnt", b_blk_cnt, 7);
            check_blk("bp_blk", b_blk, e);
            tick();
        end
        b_blk_ready = 1'b1;
        wait_drain("drain_wide");

        // 6: restart mid-message, then reset while holding a full block
        s_pulse_start();
        for (int i = 0; i < 30; i++) s_send(8'(8'hC0 + i));
        s_pulse_start();
        s_send(8'h61); s_send(8'h62); s_send(8'h63);
        push_s(ramp(3, 'h61), 3, 1'b1);
        s_pulse_finish();
        wait_drain("drain_restart");

        s_pulse_start();
        for (int i = 0; i < 64; i++) s_send(8'(i));
        rst_n = 1'b0;
        #1;
        check("arst_din_ready", 64'(s_din_ready), 0);
        check("arst_blk_valid", 64'(s_blk_valid), 0);
        check("arst_blk_last", 64'(s_blk_last), 0);
        check("arst_blk_cnt", s_blk_cnt, 0);
        check_blk("arst_blk", 1024'(s_blk), '0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
